// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: D-stage stall control for the five-stage pipeline.
// Tracks per-register Tnew countdowns plus a HI/LO multiply/divide busy counter.
module hazard_scoreboard #(
    parameter int NREG     = 32,
    parameter int REG_AW   = 5,
    parameter int TNEW_W   = 2,
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int MD_CNT_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dec_valid,
    input  logic [REG_AW-1:0] dec_rs,
    input  logic [REG_AW-1:0] dec_rt,
    input  logic              dec_rs_use,
    input  logic              dec_rt_use,
    input  logic [TNEW_W-1:0] dec_tuse_rs,
    input  logic [TNEW_W-1:0] dec_tuse_rt,
    input  logic              dec_wr,
    input  logic [REG_AW-1:0] dec_dst,
    input  logic [TNEW_W-1:0] dec_tnew,
    input  logic              dec_md,
    input  logic              md_start,
    input  logic              md_kind,
    output logic              stall,
    output logic [1:0]        stall_cause,
    output logic              md_busy
);

    logic [TNEW_W-1:0]   sb_q [1:NREG-1];
    logic [TNEW_W-1:0]   sb_d [1:NREG-1];
    logic [MD_CNT_W-1:0] md_cnt_q;
    logic [MD_CNT_W-1:0] md_cnt_d;
    logic [TNEW_W-1:0]   rs_cnt;
    logic [TNEW_W-1:0]   rt_cnt;
    logic                raw_rs;
    logic                raw_rt;
    logic                md_haz;
    logic                issue;

    // Fetch pending countdown of each source; $0 always reads as ready.
    always_comb begin
        rs_cnt = '0;
        rt_cnt = '0;
        for (int r = 1; r < NREG; r++) begin
            if (dec_rs == REG_AW'(r)) rs_cnt = sb_q[r];
            if (dec_rt == REG_AW'(r)) rt_cnt = sb_q[r];
        end
    end

    // Zero-latency hazard decision from decoded fields and current state.
    always_comb begin
        raw_rs      = dec_valid & dec_rs_use & (rs_cnt > dec_tuse_rs);
        raw_rt      = dec_valid & dec_rt_use & (rt_cnt > dec_tuse_rt);
        md_haz      = dec_valid & dec_md & (md_start | (md_cnt_q != '0));
        stall       = raw_rs | raw_rt | md_haz;
        stall_cause = {md_haz, raw_rs | raw_rt};
        issue       = dec_valid & ~stall;
        md_busy     = (md_cnt_q != '0);
    end

    // Saturating countdown; an issuing writer overrides its entry.
    always_comb begin
        for (int r = 1; r < NREG; r++) begin
            sb_d[r] = (sb_q[r] == '0) ? '0 : sb_q[r] - TNEW_W'(1);
            if (issue && dec_wr && (dec_dst == REG_AW'(r))) begin
                sb_d[r] = dec_tnew;
            end
        end
    end

    // MD busy counter: a start always reloads, even mid-count.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (md_start) begin
            md_cnt_d = md_kind ? MD_CNT_W'(DIV_CYC) : MD_CNT_W'(MULT_CYC);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - MD_CNT_W'(1);
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 1; r < NREG; r++) begin
                sb_q[r] <= '0;
            end
            md_cnt_q <= '0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                sb_q[r] <= sb_d[r];
            end
            md_cnt_q <= md_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed vector table plus randomized traffic
// checked against a ready-time model of the hazard scoreboard.
module tb_hazard_scoreboard;

    localparam int MULT_CYC = 5;
    localparam int DIV_CYC  = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       dec_valid;
    logic [4:0] dec_rs;
    logic [4:0] dec_rt;
    logic       dec_rs_use;
    logic       dec_rt_use;
    logic [1:0] dec_tuse_rs;
    logic [1:0] dec_tuse_rt;
    logic       dec_wr;
    logic [4:0] dec_dst;
    logic [1:0] dec_tnew;
    logic       dec_md;
    logic       md_start;
    logic       md_kind;
    logic       stall;
    logic [1:0] stall_cause;
    logic       md_busy;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .NREG(32), .REG_AW(5), .TNEW_W(2),
        .MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC), .MD_CNT_W(4)
    ) dut (
        .clk(clk), .reset(reset),
        .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt),
        .dec_rs_use(dec_rs_use), .dec_rt_use(dec_rt_use),
        .dec_tuse_rs(dec_tuse_rs), .dec_tuse_rt(dec_tuse_rt),
        .dec_wr(dec_wr), .dec_dst(dec_dst), .dec_tnew(dec_tnew),
        .dec_md(dec_md), .md_start(md_start), .md_kind(md_kind),
        .stall(stall), .stall_cause(stall_cause), .md_busy(md_busy)
    );

    typedef struct {
        logic       val;
        logic [4:0] rs;
        logic       rsu;
        logic [1:0] tur;
        logic [4:0] rt;
        logic       rtu;
        logic [1:0] tut;
        logic       wr;
        logic [4:0] dst;
        logic [1:0] tn;
        logic       md;
        logic       ms;
        logic       mk;
        logic       es;
        logic [1:0] ec;
        logic       eb;
    } vec_t;

    int errors = 0;
    int checks = 0;

    // Model: absolute cycle at which each value / the MD unit becomes ready.
    int cyc = 0;
    int ready [32];
    int md_end = 0;

    function automatic vec_t v(int val, int rs, int rsu, int tur,
                               int rt, int rtu, int tut,
                               int wr, int dst, int tn,
                               int md, int ms, int mk,
                               int es, int ec, int eb);
        vec_t x;
        x.val = 1'(val); x.rs = 5'(rs); x.rsu = 1'(rsu); x.tur = 2'(tur);
        x.rt = 5'(rt); x.rtu = 1'(rtu); x.tut = 2'(tut);
        x.wr = 1'(wr); x.dst = 5'(dst); x.tn = 2'(tn);
        x.md = 1'(md); x.ms = 1'(ms); x.mk = 1'(mk);
        x.es = 1'(es); x.ec = 2'(ec); x.eb = 1'(eb);
        return x;
    endfunction

    function automatic int remaining(int r);
        if (r == 0) return 0;
        return (ready[r] > cyc) ? ready[r] - cyc : 0;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) ready[r] = 0;
        md_end = 0;
    endtask

    task automatic model_eval(output logic s, output logic [1:0] c,
                              output logic b);
        logic hr, ht, hm;
        int mleft;
        mleft = (md_end > cyc) ? md_end - cyc : 0;
        hr = dec_valid && dec_rs_use && (remaining(int'(dec_rs)) > int'(dec_tuse_rs));
        ht = dec_valid && dec_rt_use && (remaining(int'(dec_rt)) > int'(dec_tuse_rt));
        hm = dec_valid && dec_md && (md_start || mleft != 0);
        s = hr || ht || hm;
        c = {hm, hr || ht};
        b = (mleft != 0);
    endtask

    // Advance model across one clock edge using the current D-stage inputs.
    task automatic model_clock();
        logic s, b;
        logic [1:0] c;
        model_eval(s, c, b);
        if (dec_valid && !s && dec_wr && dec_dst != 0)
            ready[dec_dst] = cyc + 1 + int'(dec_tnew);
        if (md_start)
            md_end = cyc + 1 + (md_kind ? DIV_CYC : MULT_CYC);
        cyc++;
    endtask

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(vec_t x);
        dec_valid = x.val; dec_rs = x.rs; dec_rs_use = x.rsu;
        dec_tuse_rs = x.tur; dec_rt = x.rt; dec_rt_use = x.rtu;
        dec_tuse_rt = x.tut; dec_wr = x.wr; dec_dst = x.dst;
        dec_tnew = x.tn; dec_md = x.md; md_start = x.ms; md_kind = x.mk;
    endtask

    task automatic run_vec(string tag, vec_t x);
        @(negedge clk);
        drive(x);
        #1;
        check({tag, ".stall"}, int'(stall), int'(x.es));
        check({tag, ".cause"}, int'(stall_cause), int'(x.ec));
        check({tag, ".busy"}, int'(md_busy), int'(x.eb));
        model_clock();
    endtask

    vec_t tab[$];
    vec_t idle;

    initial begin
        idle = v(0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0);
        model_reset();
        reset = 1'b1;
        drive(idle);
        #2;
        check("rst.stall", int'(stall), 0);
        check("rst.cause", int'(stall_cause), 0);
        check("rst.busy", int'(md_busy), 0);
        @(negedge clk);
        reset = 1'b0;

        // load-use
        tab.push_back(v(1,1,1,1, 0,0,0, 1,8,2,  0,0,0, 0,0,0));
        tab.push_back(v(1,8,1,1, 0,0,0, 1,10,1, 0,0,0, 1,1,0));
        tab.push_back(v(1,8,1,1, 0,0,0, 1,10,1, 0,0,0, 0,0,0));
        // branch after addu / lw / $0
        tab.push_back(v(1,0,0,0, 0,0,0, 1,9,1,  0,0,0, 0,0,0));
        tab.push_back(v(1,0,0,0, 9,1,0, 0,0,0,  0,0,0, 1,1,0));
        tab.push_back(v(1,0,0,0, 9,1,0, 0,0,0,  0,0,0, 0,0,0));
        tab.push_back(v(1,0,0,0, 0,0,0, 1,9,2,  0,0,0, 0,0,0));
        tab.push_back(v(1,0,0,0, 9,1,0, 0,0,0,  0,0,0, 1,1,0));
        tab.push_back(v(1,0,0,0, 9,1,0, 0,0,0,  0,0,0, 1,1,0));
        tab.push_back(v(1,0,0,0, 9,1,0, 0,0,0,  0,0,0, 0,0,0));
        tab.push_back(v(1,0,0,0, 0,0,0, 1,0,2,  0,0,0, 0,0,0));
        tab.push_back(v(1,0,1,0, 0,1,0, 0,0,0,  0,0,0, 0,0,0));
        // overwrite by a newer writer with a smaller count
        tab.push_back(v(1,0,0,0, 0,0,0, 1,4,3,  0,0,0, 0,0,0));
        tab.push_back(v(1,2,1,0, 0,0,0, 1,4,1,  0,0,0, 0,0,0));
        tab.push_back(v(1,4,1,1, 0,0,0, 1,3,1,  0,0,0, 0,0,0));
        // valid drop while stalled
        tab.push_back(v(1,0,0,0, 0,0,0, 1,6,2,  0,0,0, 0,0,0));
        tab.push_back(v(1,6,1,0, 0,0,0, 0,0,0,  0,0,0, 1,1,0));
        tab.push_back(v(0,6,1,0, 0,0,0, 0,0,0,  0,0,0, 0,0,0));
        tab.push_back(v(1,6,1,0, 0,0,0, 0,0,0,  0,0,0, 0,0,0));
        // tnew 0, own-write not self-checked
        tab.push_back(v(1,0,0,0, 0,0,0, 1,7,0,  0,0,0, 0,0,0));
        tab.push_back(v(1,0,0,0, 7,1,0, 0,0,0,  0,0,0, 0,0,0));
        tab.push_back(v(1,11,1,0, 0,0,0, 1,11,2, 0,0,0, 0,0,0));
        tab.push_back(v(1,11,1,0, 0,0,0, 0,0,0, 0,0,0, 1,1,0));
        tab.push_back(v(1,11,1,0, 0,0,0, 0,0,0, 0,0,0, 1,1,0));
        tab.push_back(v(1,11,1,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0));
        // mult with mflo in D
        tab.push_back(v(1,0,0,0, 0,0,0, 0,0,0,  1,1,0, 1,2,0));
        for (int i = 0; i < MULT_CYC; i++)
            tab.push_back(v(1,0,0,0, 0,0,0, 0,0,0, 1,0,0, 1,2,1));
        tab.push_back(v(1,0,0,0, 0,0,0, 0,0,0,  1,0,0, 0,0,0));
        // div with mflo in D
        tab.push_back(v(1,0,0,0, 0,0,0, 0,0,0,  1,1,1, 1,2,0));
        for (int i = 0; i < DIV_CYC; i++)
            tab.push_back(v(1,0,0,0, 0,0,0, 0,0,0, 1,0,0, 1,2,1));
        tab.push_back(v(1,0,0,0, 0,0,0, 0,0,0,  1,0,0, 0,0,0));
        // combined RAW + MD
        tab.push_back(v(1,0,0,0, 0,0,0, 0,0,0,  0,1,0, 0,0,0));
        tab.push_back(v(0,0,0,0, 0,0,0, 0,0,0,  0,0,0, 0,0,1));
        tab.push_back(v(0,0,0,0, 0,0,0, 0,0,0,  0,0,0, 0,0,1));
        tab.push_back(v(1,0,0,0, 0,0,0, 1,12,2, 0,0,0, 0,0,1));
        tab.push_back(v(1,12,1,1, 0,0,0, 0,0,0, 1,0,0, 1,3,1));
        tab.push_back(v(1,12,1,1, 0,0,0, 0,0,0, 1,0,0, 1,2,1));
        tab.push_back(v(1,12,1,1, 0,0,0, 0,0,0, 1,0,0, 0,0,0));

        foreach (tab[i]) run_vec($sformatf("vec%0d", i), tab[i]);

        // async reset in the middle of a stall
        run_vec("ar0", v(0,0,0,0, 0,0,0, 0,0,0, 0,1,0, 0,0,0));
        run_vec("ar1", v(0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,1));
        run_vec("ar2", v(1,0,0,0, 0,0,0, 1,5,2, 0,0,0, 0,0,1));
        @(negedge clk);
        drive(v(1,5,1,0, 0,0,0, 0,0,0, 1,0,0, 0,0,0));
        #1;
        check("ar3.stall", int'(stall), 1);
        check("ar3.cause", int'(stall_cause), 3);
        check("ar3.busy", int'(md_busy), 1);
        #1 reset = 1'b1;
        #1;
        check("arst.stall", int'(stall), 0);
        check("arst.cause", int'(stall_cause), 0);
        check("arst.busy", int'(md_busy), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post.stall", int'(stall), 0);
        check("post.busy", int'(md_busy), 0);
        model_clock();

        // randomized traffic against the ready-time model
        for (int n = 0; n < 400; n++) begin
            logic es, eb;
            logic [1:0] ec;
            @(negedge clk);
            dec_valid   = ($urandom_range(0, 7) != 0);
            dec_rs      = 5'($urandom_range(0, 7));
            dec_rt      = 5'($urandom_range(0, 7));
            dec_rs_use  = 1'($urandom_range(0, 1));
            dec_rt_use  = 1'($urandom_range(0, 1));
            dec_tuse_rs = 2'($urandom_range(0, 3));
            dec_tuse_rt = 2'($urandom_range(0, 3));
            dec_wr      = 1'($urandom_range(0, 1));
            dec_dst     = 5'($urandom_range(0, 7));
            dec_tnew    = 2'($urandom_range(0, 3));
            dec_md      = ($urandom_range(0, 3) == 0);
            md_start    = ($urandom_range(0, 9) == 0);
            md_kind     = 1'($urandom_range(0, 1));
            #1;
            model_eval(es, ec, eb);
            check($sformatf("rnd%0d.stall", n), int'(stall), int'(es));
            check($sformatf("rnd%0d.cause", n), int'(stall_cause), int'(ec));
            check($sformatf("rnd%0d.busy", n), int'(md_busy), int'(eb));
            model_clock();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
